// File: rtl/lcd_byte_writer_pkg.sv
// Shared types and HD44780 constants for the LCD byte writer.
// One-hot state encoding lets outputs come straight off flop bits.
package lcd_byte_writer_pkg;

  localparam int ST_IDLE  = 0;
  localparam int ST_SETUP = 1;
  localparam int ST_PULSE = 2;
  localparam int ST_HOLD  = 3;
  localparam int ST_EXEC  = 4;
  localparam int ST_DONE  = 5;

  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_SETUP = 6'b000010,
    S_PULSE = 6'b000100,
    S_HOLD  = 6'b001000,
    S_EXEC  = 6'b010000,
    S_DONE  = 6'b100000
  } state_t;

  localparam logic [7:0] CMD_CLEAR           = 8'h01;
  localparam logic [7:0] CMD_HOME            = 8'h02;
  localparam logic [7:0] CMD_FUNC_SET_8BIT_2 = 8'h38;
  localparam logic [7:0] CMD_DISP_ON         = 8'h0C;
  localparam logic [7:0] CMD_ENTRY_INC       = 8'h06;

  // Clear display and return home need the long execution wait
  function automatic logic is_long_cmd(
    input logic [7:0] db,
    input logic       cmd
  );
    return cmd && (db[7:2] == 6'd0) && (db[1:0] != 2'd0);
  endfunction

endpackage

// File: rtl/lcd_byte_writer_if.sv
// Start/finished handshake between an LCD initiator and the byte writer.
// master = initiator, slave = lcd_byte_writer.
interface lcd_byte_writer_if;
  logic       start;
  logic [7:0] DB;
  logic       is_command;
  logic       finished;
  logic       busy;

  modport master (
    output start, DB, is_command,
    input  finished, busy
  );

  modport slave (
    input  start, DB, is_command,
    output finished, busy
  );
endinterface

// File: rtl/lcd_byte_writer.sv
// HD44780 write-cycle generator: setup, E pulse, hold, then a count-based
// execution wait before a one-cycle finished pulse.
module lcd_byte_writer
  import lcd_byte_writer_pkg::*;
#(
  parameter int SETUP_CYCLES     = 4,
  parameter int EN_HIGH_CYCLES   = 25,
  parameter int HOLD_CYCLES      = 4,
  parameter int EXEC_CYCLES      = 2500,
  parameter int LONG_EXEC_CYCLES = 100000,
  parameter int CNT_W            = 20
) (
  input  logic               sm_clk,
  input  logic               reset,
  lcd_byte_writer_if.slave   bus,
  output logic [7:0]         lcd_data,
  output logic               lcd_rs,
  output logic               lcd_rw,
  output logic               lcd_en
);

  localparam logic [CNT_W-1:0] SETUP_LD =
    CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] EN_LD =
    CNT_W'(EN_HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD =
    CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] EXEC_LD =
    CNT_W'(EXEC_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LD =
    CNT_W'(LONG_EXEC_CYCLES - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0]       data_n;
  logic             rs_n;
  logic             long_q, long_n;
  logic             cnt_zero;

  assign cnt_zero = (cnt == '0);

  always_ff @(posedge sm_clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      lcd_data <= 8'h00;
      lcd_rs   <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      lcd_data <= data_n;
      lcd_rs   <= rs_n;
      long_q   <= long_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    data_n  = lcd_data;
    rs_n    = lcd_rs;
    long_n  = long_q;
    unique case (1'b1)
      state[ST_IDLE]: begin
        if (bus.start) begin
          data_n  = bus.DB;
          rs_n    = ~bus.is_command;
          long_n  = is_long_cmd(bus.DB, bus.is_command);
          cnt_n   = SETUP_LD;
          state_n = S_SETUP;
        end
      end
      state[ST_SETUP]: begin
        if (cnt_zero) begin
          cnt_n   = EN_LD;
          state_n = S_PULSE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      state[ST_PULSE]: begin
        if (cnt_zero) begin
          cnt_n   = HOLD_LD;
          state_n = S_HOLD;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      state[ST_HOLD]: begin
        if (cnt_zero) begin
          cnt_n   = long_q ? LONG_LD : EXEC_LD;
          state_n = S_EXEC;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      state[ST_EXEC]: begin
        if (cnt_zero) begin
          state_n = S_DONE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      state[ST_DONE]: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Straight flop bits, so E and finished cannot glitch
  assign lcd_en       = state[ST_PULSE];
  assign bus.finished = state[ST_DONE];
  assign bus.busy     = ~state[ST_IDLE];
  assign lcd_rw       = 1'b0;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Directed bench for lcd_byte_writer with short phase parameters.
// k counts cycles after the edge that accepts start (k=1 is the first).
module tb_lcd_byte_writer;
  import lcd_byte_writer_pkg::*;

  logic       sm_clk = 1'b0;
  logic       reset  = 1'b0;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en;

  lcd_byte_writer_if bus ();

  lcd_byte_writer #(
    .SETUP_CYCLES    (2),
    .EN_HIGH_CYCLES  (3),
    .HOLD_CYCLES     (2),
    .EXEC_CYCLES     (5),
    .LONG_EXEC_CYCLES(20),
    .CNT_W           (20)
  ) dut (
    .sm_clk  (sm_clk),
    .reset   (reset),
    .bus     (bus),
    .lcd_data(lcd_data),
    .lcd_rs  (lcd_rs),
    .lcd_rw  (lcd_rw),
    .lcd_en  (lcd_en)
  );

  always #5 sm_clk = ~sm_clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] en_m, fin_m, busy_m;
  logic [7:0]  d_first, d_last;
  logic        rs_first, rs_last;

  task automatic issue(input logic [7:0] db, input logic cmd);
    bus.start      = 1'b1;
    bus.DB         = db;
    bus.is_command = cmd;
    @(posedge sm_clk);
    #1;
    bus.start      = 1'b0;
    bus.DB         = 8'hA5;
    bus.is_command = ~cmd;
  endtask

  task automatic observe(
    input int         n,
    input int         inj_k,
    input logic [7:0] inj_db
  );
    en_m   = '0;
    fin_m  = '0;
    busy_m = '0;
    for (int k = 1; k <= n; k++) begin
      en_m[k]   = lcd_en;
      fin_m[k]  = bus.finished;
      busy_m[k] = bus.busy;
      if (k == 1) begin
        d_first  = lcd_data;
        rs_first = lcd_rs;
      end
      if (k == inj_k) begin
        bus.start      = 1'b1;
        bus.DB         = inj_db;
        bus.is_command = 1'b0;
      end
      @(posedge sm_clk);
      #1;
      bus.start = 1'b0;
    end
    d_last  = lcd_data;
    rs_last = lcd_rs;
  endtask

  task automatic test_reset();
    bus.start      = 1'b0;
    bus.DB         = 8'h00;
    bus.is_command = 1'b0;
    reset          = 1'b0;
    repeat (3) @(posedge sm_clk);
    #1;
    reset = 1'b1;
    n_checks++;
    if ({lcd_en, lcd_rs, lcd_rw, bus.busy, bus.finished} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl got %b exp 00000",
        {lcd_en, lcd_rs, lcd_rw, bus.busy, bus.finished});
    end
    n_checks++;
    if (lcd_data !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_data got %h exp 00", lcd_data);
    end
    bus.DB = 8'h77;
    observe(50, 0, 8'h00);
    n_checks++;
    if ({en_m, fin_m, busy_m} !== '0) begin
      n_errors++;
      $display("FAIL idle_quiet en %h fin %h busy %h exp 0",
        en_m, fin_m, busy_m);
    end
    n_checks++;
    if (d_last !== 8'h00) begin
      n_errors++;
      $display("FAIL idle_data got %h exp 00", d_last);
    end
  endtask

  task automatic test_data_write();
    issue(8'h41, 1'b0);
    observe(20, 0, 8'h00);
    n_checks++;
    if (d_first !== 8'h41 || rs_first !== 1'b1) begin
      n_errors++;
      $display("FAIL data_latch got %h/%b exp 41/1", d_first, rs_first);
    end
    n_checks++;
    if (en_m !== 64'h38) begin
      n_errors++;
      $display("FAIL data_en got %h exp 38", en_m);
    end
    n_checks++;
    if (fin_m !== 64'h2000) begin
      n_errors++;
      $display("FAIL data_fin got %h exp 2000", fin_m);
    end
    n_checks++;
    if (busy_m !== 64'h3FFE) begin
      n_errors++;
      $display("FAIL data_busy got %h exp 3ffe", busy_m);
    end
    n_checks++;
    if (d_last !== 8'h41 || rs_last !== 1'b1 || lcd_rw !== 1'b0) begin
      n_errors++;
      $display("FAIL data_hold got %h/%b/%b exp 41/1/0",
        d_last, rs_last, lcd_rw);
    end
  endtask

  task automatic test_exec_len();
    logic [7:0] db_t  [7] = '{8'h01, 8'h02, 8'h38, 8'h03,
                              8'h01, 8'h0C, 8'h04};
    logic       cmd_t [7] = '{1'b1, 1'b1, 1'b1, 1'b1,
                              1'b0, 1'b1, 1'b1};
    logic       rs_t  [7] = '{1'b0, 1'b0, 1'b0, 1'b0,
                              1'b1, 1'b0, 1'b0};
    int         fin_t [7] = '{28, 28, 13, 28, 13, 13, 13};
    logic [63:0] one = 64'd1;
    for (int i = 0; i < 7; i++) begin
      issue(db_t[i], cmd_t[i]);
      observe(35, 0, 8'h00);
      n_checks++;
      if (d_first !== db_t[i] || rs_first !== rs_t[i]) begin
        n_errors++;
        $display("FAIL exec_latch[%0d] got %h/%b exp %h/%b",
          i, d_first, rs_first, db_t[i], rs_t[i]);
      end
      n_checks++;
      if (fin_m !== (one << fin_t[i])) begin
        n_errors++;
        $display("FAIL exec_fin[%0d] got %h exp bit %0d",
          i, fin_m, fin_t[i]);
      end
      n_checks++;
      if (busy_m !== ((one << (fin_t[i] + 1)) - 64'd2)) begin
        n_errors++;
        $display("FAIL exec_busy[%0d] got %h exp bits 1..%0d",
          i, busy_m, fin_t[i]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    issue(8'h41, 1'b0);
    observe(20, 3, 8'hFF);
    n_checks++;
    if (fin_m !== 64'h2000 || en_m !== 64'h38) begin
      n_errors++;
      $display("FAIL busy_ign fin %h en %h exp 2000/38", fin_m, en_m);
    end
    n_checks++;
    if (d_last !== 8'h41 || rs_last !== 1'b1) begin
      n_errors++;
      $display("FAIL busy_ign_data got %h/%b exp 41/1", d_last, rs_last);
    end
    issue(8'h33, 1'b0);
    observe(20, 13, 8'hEE);
    n_checks++;
    if (fin_m !== 64'h2000 || busy_m !== 64'h3FFE) begin
      n_errors++;
      $display("FAIL done_ign fin %h busy %h exp 2000/3ffe",
        fin_m, busy_m);
    end
    n_checks++;
    if (d_last !== 8'h33) begin
      n_errors++;
      $display("FAIL done_ign_data got %h exp 33", d_last);
    end
  endtask

  task automatic test_reset_mid();
    issue(8'h55, 1'b1);
    observe(3, 0, 8'h00);
    n_checks++;
    if (lcd_en !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_pre_en got %b exp 1", lcd_en);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({lcd_en, bus.busy, bus.finished, lcd_rs} !== 4'b0) begin
      n_errors++;
      $display("FAIL mid_rst got %b exp 0000",
        {lcd_en, bus.busy, bus.finished, lcd_rs});
    end
    n_checks++;
    if (lcd_data !== 8'h00) begin
      n_errors++;
      $display("FAIL mid_rst_data got %h exp 00", lcd_data);
    end
    repeat (2) @(posedge sm_clk);
    #1;
    reset = 1'b1;
    observe(20, 0, 8'h00);
    n_checks++;
    if ({fin_m, busy_m, en_m} !== '0) begin
      n_errors++;
      $display("FAIL mid_abandon fin %h busy %h en %h exp 0",
        fin_m, busy_m, en_m);
    end
    issue(8'h42, 1'b0);
    observe(20, 0, 8'h00);
    n_checks++;
    if (fin_m !== 64'h2000 || d_first !== 8'h42 || rs_first !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_after fin %h data %h rs %b exp 2000/42/1",
        fin_m, d_first, rs_first);
    end
  endtask

  task automatic test_back_to_back();
    issue(8'h61, 1'b0);
    observe(40, 14, 8'h62);
    n_checks++;
    if (fin_m !== 64'h0800_2000) begin
      n_errors++;
      $display("FAIL b2b_fin got %h exp 08002000", fin_m);
    end
    n_checks++;
    if (busy_m !== (64'h3FFE | (64'h3FFE << 14))) begin
      n_errors++;
      $display("FAIL b2b_busy got %h exp %h",
        busy_m, 64'h3FFE | (64'h3FFE << 14));
    end
    n_checks++;
    if (en_m !== (64'h38 | (64'h38 << 14))) begin
      n_errors++;
      $display("FAIL b2b_en got %h exp %h", en_m, 64'h38 | (64'h38 << 14));
    end
    n_checks++;
    if (d_last !== 8'h62) begin
      n_errors++;
      $display("FAIL b2b_data got %h exp 62", d_last);
    end
  endtask

  initial begin
    test_reset();
    test_data_write();
    test_exec_len();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
